// File: rtl/tick_period_meter.sv
// Measures the period of a slow asynchronous square wave in clk_in cycles,
// with loss-of-signal timeout and a lock indicator. All outputs are registered.
module tick_period_meter #(
    parameter logic [24:0] TIMEOUT_CYCLES = 25'd25000000,
    parameter int          SYNC_STAGES    = 2
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        sig_in,
    output logic [24:0] period,
    output logic        period_valid,
    output logic        timeout,
    output logic        locked
);

    typedef enum logic {
        WAIT_EDGE,
        MEASURE
    } state_t;

    // Edges are ignored until both the synchronizer and its delay flop hold post-reset samples.
    localparam logic [2:0] FILL_DONE = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_dly_q, sync_dly_d;
    logic [2:0]             fill_q, fill_d;
    logic                   rise_q, rise_d;

    state_t                 state_q, state_d;
    logic [24:0]            counter_q, counter_d;
    logic [24:0]            capture_q, capture_d;
    logic                   report_q, report_d;
    logic                   lock_flag_q, lock_flag_d;
    logic                   timeout_flag_q, timeout_flag_d;

    logic [24:0]            period_q, period_d;
    logic                   period_valid_q, period_valid_d;
    logic                   locked_q, locked_d;
    logic                   timeout_q, timeout_d;

    logic                   at_limit;

    assign at_limit = (counter_q == TIMEOUT_CYCLES);

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], sig_in};
        sync_dly_d = sync_q[SYNC_STAGES-1];
        fill_d     = (fill_q == FILL_DONE) ? fill_q : fill_q + 3'd1;
        rise_d     = (fill_q == FILL_DONE) && sync_q[SYNC_STAGES-1] && !sync_dly_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_q     <= '0;
            sync_dly_q <= 1'b0;
            fill_q     <= 3'd0;
            rise_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            sync_dly_q <= sync_dly_d;
            fill_q     <= fill_d;
            rise_q     <= rise_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= WAIT_EDGE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_EDGE: begin
                if (rise_q) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (!rise_q && at_limit) begin
                    state_d = WAIT_EDGE;
                end
            end
            default: state_d = WAIT_EDGE;
        endcase
    end

    // An edge arriving on the same cycle the counter hits the limit is reported, not timed out.
    always_comb begin
        counter_d      = counter_q;
        capture_d      = capture_q;
        report_d       = 1'b0;
        lock_flag_d    = lock_flag_q;
        timeout_flag_d = timeout_flag_q;
        case (state_q)
            WAIT_EDGE: begin
                counter_d = 25'd0;
                if (rise_q) begin
                    counter_d      = 25'd1;
                    timeout_flag_d = 1'b0;
                end
            end
            MEASURE: begin
                if (rise_q) begin
                    report_d    = 1'b1;
                    capture_d   = counter_q;
                    counter_d   = 25'd1;
                    lock_flag_d = 1'b1;
                end else if (at_limit) begin
                    timeout_flag_d = 1'b1;
                    lock_flag_d    = 1'b0;
                    counter_d      = 25'd0;
                end else begin
                    counter_d = counter_q + 25'd1;
                end
            end
            default: begin
                counter_d = 25'd0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            counter_q      <= 25'd0;
            capture_q      <= 25'd0;
            report_q       <= 1'b0;
            lock_flag_q    <= 1'b0;
            timeout_flag_q <= 1'b0;
        end else begin
            counter_q      <= counter_d;
            capture_q      <= capture_d;
            report_q       <= report_d;
            lock_flag_q    <= lock_flag_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    always_comb begin
        period_d       = report_q ? capture_q : period_q;
        period_valid_d = report_q;
        locked_d       = lock_flag_q;
        timeout_d      = timeout_flag_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            period_q       <= 25'd0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            timeout_q      <= timeout_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// Bench for tick_period_meter: directed and random square waves compared cycle by
// cycle against an edge-timestamp reference model.
module tb_tick_period_meter;

    localparam logic [24:0] TMO   = 25'd200;
    localparam int          SYNC  = 2;
    localparam int          LAT   = SYNC + 2;
    localparam int          DEPTH = 16384;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        sig_in;
    logic [24:0] period;
    logic        period_valid;
    logic        timeout;
    logic        locked;

    tick_period_meter #(
        .TIMEOUT_CYCLES(TMO),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .sig_in      (sig_in),
        .period      (period),
        .period_valid(period_valid),
        .timeout     (timeout),
        .locked      (locked)
    );

    always #5 clk_in = ~clk_in;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    string       phase    = "init";

    logic        exp_pv   [DEPTH];
    logic [24:0] exp_per  [DEPTH];
    logic        exp_lock [DEPTH];
    logic        exp_tmo  [DEPTH];

    // Model: remembers the sample index of the last rising edge; outputs appear LAT cycles later.
    bit          m_meas;
    bit          m_prev_ok;
    bit          m_prev;
    int          m_last;
    logic [24:0] m_period;
    bit          m_locked;
    bit          m_timeout;
    bit          last_pv;

    task automatic modelStep(input logic r, input logic s, input int n);
        bit is_rise;
        bit pv;
        if (n + LAT >= DEPTH) begin
            $display("[TB] FAIL cycle_budget observed=%0d required<%0d", n + LAT, DEPTH);
            $fatal(1, "[TB] bench exceeded its cycle budget");
        end
        if (r) begin
            m_meas    = 0;
            m_prev_ok = 0;
            m_period  = '0;
            m_locked  = 0;
            m_timeout = 0;
            for (int k = 0; k <= LAT; k++) begin
                exp_pv[n+k]   = 1'b0;
                exp_per[n+k]  = '0;
                exp_lock[n+k] = 1'b0;
                exp_tmo[n+k]  = 1'b0;
            end
        end else begin
            is_rise = m_prev_ok && !m_prev && s;
            pv      = 0;
            if (is_rise) begin
                if (m_meas) begin
                    m_period = 25'(n - m_last);
                    pv       = 1;
                    m_locked = 1;
                end
                m_meas    = 1;
                m_last    = n;
                m_timeout = 0;
            end else if (m_meas && (n - m_last) == int'(TMO)) begin
                m_timeout = 1;
                m_locked  = 0;
                m_meas    = 0;
            end
            m_prev    = s;
            m_prev_ok = 1;
            exp_pv[n+LAT]   = pv;
            exp_per[n+LAT]  = m_period;
            exp_lock[n+LAT] = m_locked;
            exp_tmo[n+LAT]  = m_timeout;
        end
    endtask

    task automatic checkOutput(input int n);
        checks++;
        assert (period_valid === exp_pv[n]) else begin
            failures++;
            $error("[TB] FAIL %s period_valid cyc=%0d observed=%b expected=%b", phase, n, period_valid, exp_pv[n]);
        end
        checks++;
        assert (period === exp_per[n]) else begin
            failures++;
            $error("[TB] FAIL %s period cyc=%0d observed=%0d expected=%0d", phase, n, period, exp_per[n]);
        end
        checks++;
        assert (locked === exp_lock[n]) else begin
            failures++;
            $error("[TB] FAIL %s locked cyc=%0d observed=%b expected=%b", phase, n, locked, exp_lock[n]);
        end
        checks++;
        assert (timeout === exp_tmo[n]) else begin
            failures++;
            $error("[TB] FAIL %s timeout cyc=%0d observed=%b expected=%b", phase, n, timeout, exp_tmo[n]);
        end
        checks++;
        assert (!(last_pv && period_valid === 1'b1)) else begin
            failures++;
            $error("[TB] FAIL %s back_to_back_valid cyc=%0d observed=11 expected=not 11", phase, n);
        end
        last_pv = (period_valid === 1'b1);
    endtask

    task automatic applyStimulus(input logic r, input logic s);
        rst    = r;
        sig_in = s;
        @(posedge clk_in);
        modelStep(r, s, cyc);
        @(negedge clk_in);
        checkOutput(cyc);
        cyc++;
    endtask

    task automatic holdLevel(input logic s, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, s);
        end
    endtask

    task automatic drivePeriod(input int hi, input int lo);
        holdLevel(1'b0, lo);
        holdLevel(1'b1, hi);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            exp_pv[i]   = 1'b0;
            exp_per[i]  = '0;
            exp_lock[i] = 1'b0;
            exp_tmo[i]  = 1'b0;
        end
        m_meas    = 0;
        m_prev_ok = 0;
        m_prev    = 0;
        m_last    = 0;
        m_period  = '0;
        m_locked  = 0;
        m_timeout = 0;
        last_pv   = 0;

        phase = "reset";
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);

        phase = "period100";
        for (int i = 0; i < 6; i++) drivePeriod(50, 50);

        phase = "reset_mid";
        holdLevel(1'b0, 50);
        holdLevel(1'b1, 30);
        applyStimulus(1'b1, 1'b1);
        holdLevel(1'b1, 19);
        for (int i = 0; i < 3; i++) drivePeriod(50, 50);

        phase = "timeout";
        holdLevel(1'b0, 300);

        phase = "edge_at_limit";
        for (int i = 0; i < 4; i++) drivePeriod(100, 100);
        drivePeriod(101, 100);
        drivePeriod(100, 100);

        phase = "single_edge";
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        holdLevel(1'b0, 10);
        holdLevel(1'b1, 300);

        phase = "period2";
        for (int i = 0; i < 30; i++) drivePeriod(1, 1);

        phase = "random";
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                applyStimulus(1'b1, 1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 9) == 0) begin
                holdLevel(1'b0, $urandom_range(150, 260));
            end
            drivePeriod($urandom_range(1, 120), $urandom_range(1, 120));
        end
        holdLevel(1'b0, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tick_period_meter.md
TICK_PERIOD_METER -- requirements
Module: tick_period_meter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 25'd25000000, the maximum period measured before declaring loss of signal.
REQ-002 Parameter SYNC_STAGES, default 2, the number of input synchronizer flops (legal range 2..3).
REQ-003 clk_in  input  1  the single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 sig_in  input  1  slow, asynchronous square wave (typically a divided clock) whose period is measured.
REQ-006 period  output  25  the last completed period in clk_in cycles, unsigned.
REQ-007 period_valid  output  1  one-cycle pulse marking a new value on period.
REQ-008 timeout  output  1  level, high while no rising edge has been seen for TIMEOUT_CYCLES cycles.
REQ-009 locked  output  1  level, high after the first full period measures without an intervening timeout.

Function
REQ-010 sig_in SHALL pass through SYNC_STAGES flops, then a one-flop rising-edge detector (edge = sync & ~sync_d).
REQ-011 The FSM SHALL have states WAIT_EDGE and MEASURE.
REQ-012 WAIT_EDGE: the counter is held at 0; a detected edge loads the counter with 1 and moves to MEASURE; no period_valid.
REQ-013 MEASURE, no edge: the counter increments by 1 per cycle.
REQ-014 MEASURE, edge: period <= counter, period_valid = 1 next cycle, locked <= 1, counter <= 1, stay in MEASURE.
REQ-015 period therefore equals the exact clk_in-cycle distance between two successive detected rising edges.
REQ-016 Latency: period_valid SHALL rise exactly SYNC_STAGES+2 clk_in cycles after the first clk_in edge sampling sig_in high.
REQ-017 Timeout: in MEASURE, when counter == TIMEOUT_CYCLES and no edge arrives that cycle, timeout <= 1, locked <= 0, counter <= 0, go to WAIT_EDGE; period keeps its last value; no period_valid.
REQ-018 An edge in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win: the period is reported and no timeout occurs.
REQ-019 timeout SHALL clear on the cycle after the next detected edge.
REQ-020 The counter SHALL never exceed TIMEOUT_CYCLES and never wrap.
REQ-021 period_valid SHALL never be high for two consecutive cycles, because the minimum reportable period is 2.
REQ-022 All outputs SHALL be registered.

Reset
REQ-023 With rst high at a clk_in edge: FSM to WAIT_EDGE, counter 0, synchronizer and edge flops 0, period 0, period_valid 0, timeout 0, locked 0.
REQ-024 rst SHALL take priority over every other event, including an edge or timeout in the same cycle.
REQ-025 rst asserted mid-measurement SHALL discard the partial count; the first edge after reset only re-arms the meter and is not reported.
REQ-026 sig_in high at reset release SHALL NOT count as an edge.

Verification
REQ-027 sig_in toggles every 50 cycles (period 100) -> after the second edge, period_valid pulses once per 100 cycles with period = 100, locked = 1, timeout = 0.
REQ-028 sig_in as a single rising edge at cycle 10 -> first edge detected with no period_valid; high level held -> no further pulses.
REQ-029 TIMEOUT_CYCLES = 200, sig_in stops after lock -> timeout = 1 and locked = 0 exactly 200 cycles after the last edge; period retains its last value.
REQ-030 TIMEOUT_CYCLES = 200, edges exactly 200 cycles apart -> period = 200 reported with period_valid, timeout stays 0.
REQ-031 rst pulsed 30 cycles into a 100-cycle period -> all outputs 0; the next edge gives no pulse; the following edge reports the true period.
REQ-032 sig_in toggles every cycle (period 2) -> period = 2 and period_valid pulses every other cycle, never back-to-back.
